pll_clk_div_multi: RTL and testbench

Parametrised multi-output clock-enable generator that follows the single-output 50→25 MHz PLL wrapper. It derives NUM_CLK divided square-wave outputs and matching one-cycle enable strobes from `refclk`, each with a run-time programmable divide ratio and phase offset. Outputs are gated behind a `locked` indication that drops on every reconfiguration and returns after a fixed settle interval. It sits between the board reference clock and the per-channel pulser/beamformer timing logic.

---
 rtl/pll_clk_div_pkg.sv | 32 +++
 rtl/pll_clk_div_multi_ch.sv | 68 ++++++
 rtl/pll_clk_div_multi.sv | 123 ++++++++++++
 tb/tb_pll_clk_div_multi.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_clk_div_pkg.sv
// Shared types and divide/phase sanitising helpers for the multi-output clock-enable generator.
// Helpers work on a fixed 16-bit field; callers cast to and from their own DIV_W (DIV_W <= 16).
package pll_clk_div_pkg;

   typedef enum logic {
      SETTLE = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam int FN_W = 16;

   function automatic logic [FN_W-1:0] eff_div(input logic [FN_W-1:0] d);
      logic [FN_W-1:0] r;
      if (d < 16'd2) begin
         r = 16'd2;
      end else begin
         r = d;
      end
      return r;
   endfunction

   function automatic logic [FN_W-1:0] eff_phase(input logic [FN_W-1:0] p, input logic [FN_W-1:0] d);
      logic [FN_W-1:0] r;
      if (p < d) begin
         r = p;
      end else begin
         r = 16'd0;
      end
      return r;
   endfunction

endpackage

// File: rtl/pll_clk_div_multi_ch.sv
// One output channel: active divide ratio, phase counter and registered square-wave/strobe.
// `locked` is the lock flag for the coming cycle, so the registered outputs line up with it.
module pll_clk_div_ch
   import pll_clk_div_pkg::*;
#(
   parameter int DIV_W   = 8,
   parameter int DEF_DIV = 2
) (
   input  logic             refclk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [DIV_W-1:0] div,
   input  logic [DIV_W-1:0] phase,
   input  logic             locked,
   output logic             outclk,
   output logic             outclk_en
);

   localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(eff_div(FN_W'(DEF_DIV)));
   localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

   logic [DIV_W-1:0] div_r;
   logic [DIV_W-1:0] cnt_r;
   logic             clk_r;
   logic             en_r;
   logic [DIV_W-1:0] eff_d_s;
   logic [DIV_W-1:0] div_nxt_s;
   logic [DIV_W-1:0] cnt_nxt_s;
   logic             clk_nxt_s;
   logic             en_nxt_s;

   // Next divide/count and the output decode for the coming cycle
   always_comb begin
      eff_d_s = DIV_W'(eff_div(FN_W'(div)));
      if (load) begin
         div_nxt_s = eff_d_s;
         cnt_nxt_s = DIV_W'(eff_phase(FN_W'(phase), FN_W'(eff_d_s)));
      end else begin
         div_nxt_s = div_r;
         if (cnt_r == div_r - ONE) begin
            cnt_nxt_s = '0;
         end else begin
            cnt_nxt_s = cnt_r + ONE;
         end
      end
      clk_nxt_s = locked & (cnt_nxt_s < (div_nxt_s >> 1));
      en_nxt_s  = locked & (cnt_nxt_s == div_nxt_s - ONE);
   end

   // Channel state and registered outputs
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         div_r <= RST_DIV;
         cnt_r <= '0;
         clk_r <= 1'b0;
         en_r  <= 1'b0;
      end else begin
         div_r <= div_nxt_s;
         cnt_r <= cnt_nxt_s;
         clk_r <= clk_nxt_s;
         en_r  <= en_nxt_s;
      end
   end

   assign outclk    = clk_r;
   assign outclk_en = en_r;

endmodule

// File: rtl/pll_clk_div_multi.sv
// Multi-output clock-enable generator: lock FSM, settle counter, shadow config bank and
// the cfg handshake, with one pll_clk_div_ch per output.
module pll_clk_div_multi
   import pll_clk_div_pkg::*;
#(
   parameter int NUM_CLK  = 4,
   parameter int DIV_W    = 8,
   parameter int DEF_DIV  = 2,
   parameter int LOCK_CYC = 16,
   parameter int CH_W     = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1
) (
   input  logic               refclk,
   input  logic               rst_n,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [CH_W-1:0]    cfg_ch,
   input  logic [DIV_W-1:0]   cfg_div,
   input  logic [DIV_W-1:0]   cfg_phase,
   input  logic               cfg_commit,
   output logic [NUM_CLK-1:0] outclk,
   output logic [NUM_CLK-1:0] outclk_en,
   output logic               locked
);

   localparam int               SET_W   = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
   localparam logic [SET_W-1:0] SET_END = SET_W'(LOCK_CYC - 1);
   localparam logic [SET_W-1:0] SET_ONE = SET_W'(1);

   state_t           state_r;
   logic [SET_W-1:0] settle_r;
   logic             locked_r;
   logic [DIV_W-1:0] div_sh_r [NUM_CLK];
   logic [DIV_W-1:0] ph_sh_r  [NUM_CLK];
   logic [DIV_W-1:0] div_ld_s [NUM_CLK];
   logic [DIV_W-1:0] ph_ld_s  [NUM_CLK];
   logic             wr_en_s;
   logic             commit_s;
   logic             locked_nxt_s;

   // Handshake qualification, shadow write-through and next lock flag
   always_comb begin
      wr_en_s  = cfg_valid & locked_r;
      commit_s = cfg_commit & locked_r;
      for (int i = 0; i < NUM_CLK; i++) begin
         if (wr_en_s && (int'(cfg_ch) == i)) begin
            div_ld_s[i] = cfg_div;
            ph_ld_s[i]  = cfg_phase;
         end else begin
            div_ld_s[i] = div_sh_r[i];
            ph_ld_s[i]  = ph_sh_r[i];
         end
      end
      if (state_r == LOCKED) begin
         locked_nxt_s = ~cfg_commit;
      end else begin
         locked_nxt_s = (settle_r == SET_END);
      end
   end

   // Lock FSM, settle counter and shadow bank
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= SETTLE;
         settle_r <= '0;
         locked_r <= 1'b0;
         for (int i = 0; i < NUM_CLK; i++) begin
            div_sh_r[i] <= DIV_W'(DEF_DIV);
            ph_sh_r[i]  <= '0;
         end
      end else begin
         case (state_r)
            SETTLE: begin
               if (settle_r == SET_END) begin
                  state_r  <= LOCKED;
                  locked_r <= 1'b1;
               end else begin
                  settle_r <= settle_r + SET_ONE;
                  locked_r <= 1'b0;
               end
            end
            LOCKED: begin
               if (cfg_commit) begin
                  state_r  <= SETTLE;
                  settle_r <= '0;
                  locked_r <= 1'b0;
               end else begin
                  locked_r <= 1'b1;
               end
            end
            default: begin
               state_r  <= SETTLE;
               settle_r <= '0;
               locked_r <= 1'b0;
            end
         endcase
         for (int i = 0; i < NUM_CLK; i++) begin
            div_sh_r[i] <= div_ld_s[i];
            ph_sh_r[i]  <= ph_ld_s[i];
         end
      end
   end

   // A commit in the same cycle as a write picks the written value straight from div_ld_s
   for (genvar g = 0; g < NUM_CLK; g++) begin : g_ch
      pll_clk_div_ch #(
         .DIV_W   (DIV_W),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .refclk    (refclk),
         .rst_n     (rst_n),
         .load      (commit_s),
         .div       (div_ld_s[g]),
         .phase     (ph_ld_s[g]),
         .locked    (locked_nxt_s),
         .outclk    (outclk[g]),
         .outclk_en (outclk_en[g])
      );
   end

   assign locked    = locked_r;
   assign cfg_ready = locked_r;

endmodule

// File: tb/tb_pll_clk_div_multi.sv
// Scoreboard bench for pll_clk_div_multi: the driver queues the expected outputs for every
// cycle it issues, and a monitor on the falling edge pops and compares them.
module tb_pll_clk_div_multi;

   localparam int N    = 4;
   localparam int LOCK = 16;

   logic       refclk = 1'b0;
   logic       rst_n;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [2:0] cfg_ch;
   logic [7:0] cfg_div;
   logic [7:0] cfg_phase;
   logic       cfg_commit;
   logic [3:0] outclk;
   logic [3:0] outclk_en;
   logic       locked;

   always #5 refclk = ~refclk;

   pll_clk_div_multi #(
      .NUM_CLK  (N),
      .DIV_W    (8),
      .DEF_DIV  (2),
      .LOCK_CYC (LOCK),
      .CH_W     (3)
   ) dut (
      .refclk     (refclk),
      .rst_n      (rst_n),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ch     (cfg_ch),
      .cfg_div    (cfg_div),
      .cfg_phase  (cfg_phase),
      .cfg_commit (cfg_commit),
      .outclk     (outclk),
      .outclk_en  (outclk_en),
      .locked     (locked)
   );

   // expected vector layout: {locked, cfg_ready, outclk[3:0], outclk_en[3:0]}
   typedef struct {
      string      name;
      logic [9:0] v;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   done   = 1'b0;

   int   act_d[N];
   int   act_p[N];
   int   sh_d[N];
   int   sh_p[N];
   int   k;
   bit   in_rst;

   // k counts edges since the last restart; cnt = (P + k) mod D, outputs gated until k reaches LOCK
   function automatic logic [9:0] model_vec();
      logic       lk;
      logic [3:0] oc;
      logic [3:0] oe;
      int         c;
      lk = !in_rst && (k >= LOCK);
      for (int i = 0; i < N; i++) begin
         c     = (act_p[i] + k) % act_d[i];
         oc[i] = lk && (c < act_d[i] / 2);
         oe[i] = lk && (c == act_d[i] - 1);
      end
      return {lk, lk, oc, oe};
   endfunction

   task automatic push(input string nm, input logic [9:0] v);
      exp_t e;
      e.name = nm;
      e.v    = v;
      q.push_back(e);
   endtask

   task automatic tick(input logic v, input logic [2:0] ch, input logic [7:0] dv, input logic [7:0] ph,
                       input int ed, input int ep, input logic cm, input string nm);
      bit rdy;
      rdy        = (k >= LOCK);
      cfg_valid  = v;
      cfg_ch     = ch;
      cfg_div    = dv;
      cfg_phase  = ph;
      cfg_commit = cm;
      @(posedge refclk);
      #1;
      cfg_valid  = 1'b0;
      cfg_commit = 1'b0;
      if (v && rdy && (int'(ch) < N)) begin
         sh_d[int'(ch)] = ed;
         sh_p[int'(ch)] = ep;
      end
      if (cm && rdy) begin
         for (int i = 0; i < N; i++) begin
            act_d[i] = sh_d[i];
            act_p[i] = sh_p[i];
         end
         k = 0;
      end else begin
         k++;
      end
      push(nm, model_vec());
   endtask

   task automatic idle(input string nm);
      tick(1'b0, 3'd0, 8'd0, 8'd0, 0, 0, 1'b0, nm);
   endtask

   task automatic apply_reset(input int n, input string nm);
      logic [9:0] now_v;
      @(posedge refclk);
      #1;
      rst_n  = 1'b0;
      in_rst = 1'b1;
      #1;
      now_v = {locked, cfg_ready, outclk, outclk_en};
      checks++;
      if (now_v !== 10'b0) begin
         errors++;
         $display("FAIL %s async reset state got=%b required=%b", nm, now_v, 10'b0);
      end
      push(nm, 10'b0);
      repeat (n) begin
         @(posedge refclk);
         #1;
         push(nm, 10'b0);
      end
      rst_n  = 1'b1;
      in_rst = 1'b0;
      k      = 0;
      for (int i = 0; i < N; i++) begin
         act_d[i] = 2;
         act_p[i] = 0;
         sh_d[i]  = 2;
         sh_p[i]  = 0;
      end
   endtask

   // Monitor: compare every queued expectation against the DUT on the falling edge
   initial begin
      exp_t       e;
      logic [9:0] got;
      forever begin
         @(negedge refclk);
         while (q.size() > 0) begin
            e   = q.pop_front();
            got = {locked, cfg_ready, outclk, outclk_en};
            checks++;
            if (got !== e.v) begin
               errors++;
               $display("FAIL %s got=%b required=%b", e.name, got, e.v);
            end
         end
      end
   end

   // Watchdog: report a failure if the stimulus does not complete in time
   initial begin
      #100000;
      if (!done) begin
         errors++;
         $display("FAIL timeout waiting for stimulus to complete");
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end else begin
         $display("watchdog idle");
      end
   end

   initial begin
      rst_n      = 1'b0;
      in_rst     = 1'b1;
      k          = 0;
      cfg_valid  = 1'b0;
      cfg_ch     = 3'd0;
      cfg_div    = 8'd0;
      cfg_phase  = 8'd0;
      cfg_commit = 1'b0;

      // 1: reset defaults, lock after 16 edges, D=2 everywhere
      apply_reset(3, "t1_reset");
      repeat (15) idle("t1_settle");
      idle("t1_lock");
      push("t1_first_lock_hand", 10'b11_1111_0000);
      idle("t1_run");
      push("t1_second_hand", 10'b11_0000_1111);
      repeat (4) idle("t1_run");

      // 2: ch1 D=5 P=2, shadow only until commit
      tick(1'b1, 3'd1, 8'd5, 8'd2, 5, 2, 1'b0, "t2_write");
      repeat (2) idle("t2_shadow_only");
      tick(1'b0, 3'd0, 8'd0, 8'd0, 0, 0, 1'b1, "t2_commit");
      repeat (15) idle("t2_settle");
      idle("t2_lock");
      push("t2_first_lock_hand", 10'b11_1101_0000);
      repeat (12) idle("t2_run");

      // 3: clamped divide, out-of-range phase, out-of-range channel
      tick(1'b1, 3'd0, 8'd1, 8'd0, 2, 0, 1'b0, "t3_wr_d1");
      tick(1'b1, 3'd3, 8'd4, 8'd9, 4, 0, 1'b0, "t3_wr_p9");
      tick(1'b1, 3'd7, 8'd9, 8'd1, 0, 0, 1'b0, "t3_wr_ch7");
      tick(1'b0, 3'd0, 8'd0, 8'd0, 0, 0, 1'b1, "t3_commit");
      repeat (18) idle("t3_run");
      push("t3_k18_hand", 10'b11_0111_0000);
      repeat (8) idle("t3_run");

      // 4: write+commit in one cycle, then ignored requests during settle
      tick(1'b1, 3'd2, 8'd3, 8'd0, 3, 0, 1'b1, "t4_wr_commit");
      repeat (3) idle("t4_settle");
      tick(1'b1, 3'd0, 8'd7, 8'd1, 7, 1, 1'b1, "t4_ignored");
      repeat (12) idle("t4_settle");
      push("t4_first_lock_hand", 10'b11_1001_0000);
      repeat (8) idle("t4_run");

      // 5: reset during settle after a reconfiguration, then during lock
      tick(1'b1, 3'd1, 8'd7, 8'd0, 7, 0, 1'b0, "t5_write");
      tick(1'b0, 3'd0, 8'd0, 8'd0, 0, 0, 1'b1, "t5_commit");
      repeat (5) idle("t5_settle");
      apply_reset(2, "t5_reset_settle");
      repeat (16) idle("t5_relock");
      push("t5_relock_hand", 10'b11_1111_0000);
      repeat (6) idle("t5_run");
      apply_reset(1, "t5_reset_locked");
      repeat (18) idle("t5_relock2");

      @(negedge refclk);
      #1;
      done = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
